// File: rtl/vga_scanout_pkg.sv
// Shared types and elaboration-time helpers for the VGA scan-out engine:
// pixel formats, pixel decode to RGB444 and line/frame total arithmetic.
package vga_scanout_pkg;

    typedef enum logic [1:0] {
        FMT_I4     = 2'd0,
        FMT_RGB332 = 2'd1,
        FMT_RGB444 = 2'd2
    } pix_fmt_e;

    function automatic pix_fmt_e bpp_to_fmt(input int bpp);
        case (bpp)
            8:       return FMT_RGB332;
            16:      return FMT_RGB444;
            default: return FMT_I4;
        endcase
    endfunction

    // p holds one pixel right-aligned; bits above the pixel width are ignored.
    function automatic logic [11:0] decode_pixel(input pix_fmt_e fmt, input logic [15:0] p);
        logic [11:0] rgb;
        case (fmt)
            FMT_RGB332: rgb = {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
            FMT_RGB444: rgb = p[11:0];
            default:    rgb = {p[3:0], p[3:0], p[3:0]};
        endcase
        return rgb;
    endfunction

    function automatic int total_h(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int total_v(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Wide enough to hold the total itself, so sync-end compares never overflow.
    function automatic int cnt_width(input int total);
        return (total < 2) ? 1 : $clog2(total + 1);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with active-region, sync-window and
// frame-start decode. All outputs describe the current counter position.
module vga_timing
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic [HW-1:0] h,
    output logic          v_odd,
    output logic          h_active,
    output logic          v_active,
    output logic          hs_act,
    output logic          vs_act,
    output logic          line_end,
    output logic          frame_end,
    output logic          frame_start
);

    localparam int H_TOT = total_h(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = total_v(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        h           = h_q;
        v_odd       = v_q[0];
        h_active    = (h_q < H_ACT);
        v_active    = (v_q < V_ACT);
        hs_act      = (h_q >= HS_START) && (h_q < HS_END);
        vs_act      = (v_q >= VS_START) && (v_q < VS_END);
        line_end    = (h_q == H_LAST);
        frame_end   = (h_q == H_LAST) && (v_q == V_LAST);
        frame_start = (h_q == '0) && (v_q == '0);
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out engine: raster timing, framebuffer fetch, pixel unpack and a
// two-stage pin pipeline. Define VGA_SCANOUT_PIXDOUBLE_EN for 2x2 pixel doubling.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   BPP       = 4,
    parameter int   ADDR_W    = 16,
    parameter int   BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] address,
    output logic              rden,
    input  logic [15:0]       q,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B,
    output logic              HS,
    output logic              VS,
    output logic              de,
    output logic              frame_start
);

    localparam int       H_TOT = total_h(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int       V_TOT = total_v(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int       HW    = cnt_width(H_TOT);
    localparam int       VW    = cnt_width(V_TOT);
    localparam int       PPW   = 16 / BPP;
    localparam pix_fmt_e FMT   = bpp_to_fmt(BPP);

`ifdef VGA_SCANOUT_PIXDOUBLE_EN
    localparam int DOUBLE = 1;
    if ((H_ACTIVE % 2) != 0 || (V_ACTIVE % 2) != 0) begin : g_even_check
        $error("vga_scanout: pixel doubling needs even H_ACTIVE and V_ACTIVE");
    end
`else
    localparam int DOUBLE = 0;
`endif

    localparam int                FB_W = H_ACTIVE >> DOUBLE;
    localparam logic [ADDR_W-1:0] WPL  = ADDR_W'(FB_W / PPW);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    if (BPP != 4 && BPP != 8 && BPP != 16) begin : g_bpp_check
        $error("vga_scanout: BPP must be 4, 8 or 16");
    end

    logic [HW-1:0] h;
    logic          v_odd;
    logic          h_active;
    logic          v_active;
    logic          hs_act;
    logic          vs_act;
    logic          line_end;
    logic          frame_end;
    logic          fs_s0;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clock       (clock),
        .reset_n     (reset_n),
        .h           (h),
        .v_odd       (v_odd),
        .h_active    (h_active),
        .v_active    (v_active),
        .hs_act      (hs_act),
        .vs_act      (vs_act),
        .line_end    (line_end),
        .frame_end   (frame_end),
        .frame_start (fs_s0)
    );

    // Stage 0: frame gate, fetch address, read strobe.
    logic              gate_q, gate_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic              vis_s0;
    logic              fetch_slot;

    // Stage 1 (RAM data returning) and stage 2 (pins).
    logic        ld_p1_q, ld_p1_d;
    logic        vis_p1_q, vis_p1_d;
    logic        de_p1_q, de_p1_d;
    logic        hs_p1_q, hs_p1_d;
    logic        vs_p1_q, vs_p1_d;
    logic        fs_p1_q, fs_p1_d;
    logic        hodd_p1_q, hodd_p1_d;
    logic [15:0] sh_q, sh_d;
    logic [15:0] src;
    logic [15:0] pix;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic        fs_q, fs_d;

    always_comb begin
        vis_s0     = h_active && v_active;
        fetch_slot = vis_s0 && (DOUBLE == 0 || !h[0])
                     && (((32'(h) >> DOUBLE) & (PPW - 1)) == 0);
        rden       = fetch_slot && gate_q;
        address    = line_base_q + word_q;

        // The gate only changes on the wrap into (0,0), so a frame is all-or-nothing
        // and the partial frame right after reset stays blanked.
        gate_d      = frame_end ? enable : gate_q;
        word_d      = word_q;
        line_base_d = line_base_q;
        if (line_end) begin
            word_d = '0;
            if (frame_end) begin
                line_base_d = BASE;
            end else if (v_active && (DOUBLE == 0 || v_odd)) begin
                line_base_d = line_base_q + WPL;
            end
        end else if (fetch_slot) begin
            word_d = word_q + 1'b1;
        end

        ld_p1_d   = rden;
        vis_p1_d  = vis_s0 && gate_q;
        de_p1_d   = vis_s0;
        hs_p1_d   = hs_act ? HS_POL : ~HS_POL;
        vs_p1_d   = vs_act ? VS_POL : ~VS_POL;
        fs_p1_d   = fs_s0;
        hodd_p1_d = h[0];

        // A fresh word shows its first pixel straight from q; the shifter holds the rest.
        src  = ld_p1_q ? q : sh_q;
        pix  = src >> (16 - BPP);
        sh_d = sh_q;
        if (ld_p1_q) begin
            sh_d = (DOUBLE != 0) ? q : (q << BPP);
        end else if (vis_p1_q && (DOUBLE == 0 || hodd_p1_q)) begin
            sh_d = sh_q << BPP;
        end

        rgb_d = vis_p1_q ? decode_pixel(FMT, pix) : 12'h000;
        hs_d  = hs_p1_q;
        vs_d  = vs_p1_q;
        de_d  = de_p1_q;
        fs_d  = fs_p1_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gate_q      <= 1'b0;
            line_base_q <= BASE;
            word_q      <= '0;
            ld_p1_q     <= 1'b0;
            vis_p1_q    <= 1'b0;
            de_p1_q     <= 1'b0;
            hs_p1_q     <= ~HS_POL;
            vs_p1_q     <= ~VS_POL;
            fs_p1_q     <= 1'b0;
            hodd_p1_q   <= 1'b0;
            sh_q        <= '0;
            rgb_q       <= '0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            gate_q      <= gate_d;
            line_base_q <= line_base_d;
            word_q      <= word_d;
            ld_p1_q     <= ld_p1_d;
            vis_p1_q    <= vis_p1_d;
            de_p1_q     <= de_p1_d;
            hs_p1_q     <= hs_p1_d;
            vs_p1_q     <= vs_p1_d;
            fs_p1_q     <= fs_p1_d;
            hodd_p1_q   <= hodd_p1_d;
            sh_q        <= sh_d;
            rgb_q       <= rgb_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            fs_q        <= fs_d;
        end
    end

    always_comb begin
        VGA_R       = rgb_q[11:8];
        VGA_G       = rgb_q[7:4];
        VGA_B       = rgb_q[3:0];
        HS          = hs_q;
        VS          = vs_q;
        de          = de_q;
        frame_start = fs_q;
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with a tiny 14x7 raster: a 4 bpp instance checked by a
// queue scoreboard plus directed checks, and an 8 bpp instance for RGB332 decode.
module tb_vga_scanout;

    // Raster: H_TOTAL = 8+2+2+2 = 14, V_TOTAL = 4+1+1+1 = 7, frame = 98 clocks.
    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable4 = 1'b0;
    logic        enable8 = 1'b1;

    logic [15:0] address4, address8;
    logic        rden4, rden8;
    logic [15:0] q4 = '0;
    logic [15:0] q8 = '0;
    logic [3:0]  r4, g4, b4, r8, g8, b8;
    logic        hs4, vs4, de4, fs4, hs8, vs8, de8, fs8;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rd_first = 0;
    bit mon_en   = 1'b0;

    logic [31:0] exp_px_q[$];
    logic [31:0] exp_rd_q[$];
    logic [15:0] exp_fs_q[$];

    vga_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .BPP(4), .ADDR_W(16), .BASE_ADDR(16'h100)
    ) dut4 (
        .clock(clock), .reset_n(reset_n), .enable(enable4),
        .address(address4), .rden(rden4), .q(q4),
        .VGA_R(r4), .VGA_G(g4), .VGA_B(b4),
        .HS(hs4), .VS(vs4), .de(de4), .frame_start(fs4)
    );

    vga_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .BPP(8), .ADDR_W(16), .BASE_ADDR(16'h100)
    ) dut8 (
        .clock(clock), .reset_n(reset_n), .enable(enable8),
        .address(address8), .rden(rden8), .q(q8),
        .VGA_R(r8), .VGA_G(g8), .VGA_B(b8),
        .HS(hs8), .VS(vs8), .de(de8), .frame_start(fs8)
    );

    // ---------------- clock / cycle count / RAM models ----------------
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [15:0] mem4(input logic [15:0] a);
        case (a)
            16'h0100: return 16'h1234;
            16'h0101: return 16'h5678;
            16'h0102: return 16'h9ABC;
            16'h0103: return 16'hDEF0;
            16'h0104: return 16'h0F1E;
            16'h0105: return 16'h2D3C;
            16'h0106: return 16'h4B5A;
            16'h0107: return 16'h6978;
            default:  return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [15:0] mem8(input logic [15:0] a);
        return (a == 16'h0100) ? 16'hE01C : 16'h0000;
    endfunction

    always @(posedge clock) begin
        if (rden4) q4 <= mem4(address4);
        if (rden8) q8 <= mem8(address8);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc != n) @(negedge clock);
    endtask

    // Expected pins for one frame whose (0,0) counter cycle is base_cyc.
    task automatic push_frame(input int base_cyc, input bit lit);
        for (int v = 0; v < 4; v++) begin
            for (int x = 0; x < 8; x++) begin
                int          c;
                logic [15:0] w;
                logic [3:0]  n;
                logic [15:0] a;
                c = base_cyc + 14 * v + x + 2;
                a = 16'h0100 + 16'(2 * v + x / 4);
                w = mem4(a);
                n = w[15 - 4 * (x % 4) -: 4];
                exp_px_q.push_back({4'h0, c[15:0], lit ? {n, n, n} : 12'h000});
            end
        end
        exp_fs_q.push_back(16'(base_cyc + 2));
    endtask

    task automatic push_reads(input int base_cyc);
        for (int v = 0; v < 4; v++) begin
            for (int w = 0; w < 2; w++) begin
                logic [15:0] c;
                logic [15:0] a;
                c = 16'(base_cyc + 14 * v + 4 * w);
                a = 16'h0100 + 16'(2 * v + w);
                exp_rd_q.push_back({c, a});
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (mon_en && reset_n) begin
            if (rden4) begin
                if (cyc < 98) rd_first++;
                if (exp_rd_q.size() == 0) chk("rd_unexpected", {cyc[15:0], address4}, 32'h0);
                else chk("rd_cyc_addr", {cyc[15:0], address4}, exp_rd_q.pop_front());
            end
            if (de4) begin
                if (exp_px_q.size() == 0) chk("px_unexpected", {4'h0, cyc[15:0], r4, g4, b4}, 32'h0);
                else chk("px_cyc_rgb", {4'h0, cyc[15:0], r4, g4, b4}, exp_px_q.pop_front());
            end else begin
                chk("rgb_blank", {20'h0, r4, g4, b4}, 32'h0);
            end
            if (fs4) begin
                if (exp_fs_q.size() == 0) chk("fs_unexpected", {16'h0, cyc[15:0]}, 32'h0);
                else chk("fs_cyc", {16'h0, cyc[15:0]}, {16'h0, exp_fs_q.pop_front()});
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int rd_cnt;
        repeat (3) @(negedge clock);
        chk("rst_hs", {31'h0, hs4}, 32'h1);
        chk("rst_vs", {31'h0, vs4}, 32'h1);
        chk("rst_rgb", {20'h0, r4, g4, b4}, 32'h0);
        chk("rst_rden", {31'h0, rden4}, 32'h0);
        chk("rst_de", {31'h0, de4}, 32'h0);
        chk("rst_fs", {31'h0, fs4}, 32'h0);
        chk("rst_addr", {16'h0, address4}, 32'h0100);

        push_frame(0, 1'b0);
        mon_en  = 1'b1;
        reset_n = 1'b1;

        wait_cyc(11); chk("hs_before", {31'h0, hs4}, 32'h1);
        wait_cyc(12); chk("hs_low_12", {31'h0, hs4}, 32'h0);
        wait_cyc(13); chk("hs_low_13", {31'h0, hs4}, 32'h0);
        wait_cyc(14); chk("hs_after", {31'h0, hs4}, 32'h1);

        wait_cyc(50);
        enable4 = 1'b1;
        push_reads(98);
        push_frame(98, 1'b1);

        wait_cyc(71); chk("vs_before", {31'h0, vs4}, 32'h1);
        wait_cyc(72); chk("vs_low_72", {31'h0, vs4}, 32'h0);
        wait_cyc(85); chk("vs_low_85", {31'h0, vs4}, 32'h0);
        wait_cyc(86); chk("vs_after", {31'h0, vs4}, 32'h1);

        wait_cyc(97); chk("first_frame_reads", rd_first, 32'h0);

        wait_cyc(98);
        chk("bpp8_rden", {31'h0, rden8}, 32'h1);
        chk("bpp8_addr", {16'h0, address8}, 32'h0100);
        wait_cyc(100);
        chk("bpp8_px0", {19'h0, de8, r8, g8, b8}, {19'h0, 1'b1, 12'hF00});
        wait_cyc(101);
        chk("bpp8_px1", {19'h0, de8, r8, g8, b8}, {19'h0, 1'b1, 12'h0F0});

        wait_cyc(130);
        enable4 = 1'b0;
        push_frame(196, 1'b0);

        wait_cyc(207); chk("f3_hs_before", {31'h0, hs4}, 32'h1);
        wait_cyc(208); chk("f3_hs_low", {31'h0, hs4}, 32'h0);

        wait_cyc(290);
        mon_en = 1'b0;
        chk("px_queue_drained", exp_px_q.size(), 32'h0);
        chk("rd_queue_drained", exp_rd_q.size(), 32'h0);
        chk("fs_queue_drained", exp_fs_q.size(), 32'h0);

        wait_cyc(292);
        enable4 = 1'b1;

        // Asynchronous reset in the middle of a lit line of frame 4.
        wait_cyc(300);
        #2 reset_n = 1'b0;
        #1;
        chk("async_hs", {31'h0, hs4}, 32'h1);
        chk("async_vs", {31'h0, vs4}, 32'h1);
        chk("async_rgb", {20'h0, r4, g4, b4}, 32'h0);
        chk("async_rden", {31'h0, rden4}, 32'h0);
        chk("async_de", {31'h0, de4}, 32'h0);
        chk("async_addr", {16'h0, address4}, 32'h0100);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        rd_cnt = 0;
        for (int k = 0; k <= 20; k++) begin
            wait_cyc(k);
            if (rden4) rd_cnt++;
            if (k == 2) begin
                chk("rr_fs", {31'h0, fs4}, 32'h1);
                chk("rr_de", {31'h0, de4}, 32'h1);
                chk("rr_rgb", {20'h0, r4, g4, b4}, 32'h0);
            end
            if (k == 11) chk("rr_hs_before", {31'h0, hs4}, 32'h1);
            if (k == 12) chk("rr_hs_low", {31'h0, hs4}, 32'h0);
        end
        chk("rr_no_reads", rd_cnt, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Parametrised VGA scan-out engine: generates H/V sync and display-enable from configurable timing, fetches packed pixels from the synchronous video RAM port (1-cycle read latency), unpacks them at 4, 8 or 16 bits per pixel and drives RGB444 pins. Sits between the dual-port video RAM's VGA-side port and the VGA connector, in the VGA clock domain. Generalises the fixed-mode VGA block to arbitrary timing, pixel format, framebuffer base and frame gating.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- HS_POL / VS_POL, 0 / 0, active sync level (0 = active-low)
- BPP, 4, bits per pixel: 4, 8 or 16 only (elaboration error otherwise)
- ADDR_W, 16, RAM word-address width
- BASE_ADDR, 0, framebuffer word address of pixel (0,0)
- clock  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  scan-out gate, sampled at frame start
- address  out  ADDR_W  RAM read word address
- rden  out  1  RAM read strobe
- q  in  16  RAM read data, valid one clock after address/rden
- VGA_R / VGA_G / VGA_B  out  4 each  colour outputs
- HS / VS  out  1  syncs, polarity per HS_POL/VS_POL
- de  out  1  display enable, aligned with colour pins
- frame_start  out  1  one-clock pulse coincident with pixel (0,0) on pins

## Operation
- Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1); H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, same for V. v increments when h wraps; both wrap to 0.
- Active when h < H_ACTIVE and v < V_ACTIVE. HS active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VS likewise on v.
- PPW = 16/BPP pixels per word. In active region with frame gate set, rden=1 and address issued when h % PPW == 0; otherwise rden=0.
- Address = BASE_ADDR + (v*H_ACTIVE + h)/PPW, kept incrementally (line pointer + word counter, no multiplier); arithmetic modulo 2^ADDR_W.
- Pixels packed MSB-first: pixel 0 in q[15:16-BPP]. Returned word loaded into shift register; shifted BPP left each active clock.
- Decode: BPP=4 grey, R=G=B=p. BPP=8 RGB332, R={p[7:5],p[7]}, G={p[4:2],p[4]}, B={p[1:0],p[1:0]}. BPP=16 RGB444 in q[11:0], q[15:12] ignored.
- Frame gate: enable sampled at h=0,v=0. Gate low → whole frame issues no reads, RGB=0, de still follows timing, syncs continue. Changes of enable mid-frame take effect next frame.
- Outside active region RGB forced to 0.

## Timing
- Pipeline: stage 0 counters/address, stage 1 RAM, stage 2 registered pins. HS, VS, de, frame_start delayed 2 clocks to match colour.
- Pixel at counter (h,v) appears on pins 2 clocks later; rden→pins latency 2.
- Reset (asynchronous, immediate): h=v=0, frame gate=0, rden=0, address=BASE_ADDR, RGB=0, de=0, frame_start=0, HS=~HS_POL, VS=~VS_POL. First frame after reset is always blanked (gate cleared); scanning restarts at (0,0).
- Reset mid-line: in-flight RAM data discarded; no partial pixels emitted.

## Configuration
- VGA_SCANOUT_PIXDOUBLE_EN defined: framebuffer is (H_ACTIVE/2)×(V_ACTIVE/2); each pixel shown 2 clocks and each line repeated on 2 scan lines (same addresses re-read); x_fb=h>>1, y_fb=v>>1; fetch when x_fb % PPW == 0 and h even. H_ACTIVE, V_ACTIVE must be even.
- Undefined: 1:1 mapping as above.

## Structure
- vga_scanout_pkg: pixel-format enum (FMT_I4, FMT_RGB332, FMT_RGB444), BPP→format function, pixel-decode function returning 12-bit RGB, H_TOTAL/V_TOTAL helper functions.
- Sub-module vga_timing: h/v counters, sync/active generation, frame-start strobe; vga_scanout adds fetch, unpack and output pipeline.

## Test plan
Bench timing: H 8/2/2/2, V 4/1/1/1, BPP=4, BASE_ADDR=0x100, polarity 0.
- Reset release → HS=VS=1, RGB=0, rden=0, de=0; first frame no reads; HS low for h=10..11 appearing at clocks 12..13.
- enable=1 before 2nd frame → rden at h=0,4 each active line; addresses 0x100,0x101,0x102,0x103,…,0x107; rows contiguous.
- q=16'h1234 for 0x100 → pins show grey 1,2,3,4 on 4 consecutive clocks, de=1, frame_start=1 on first.
- enable dropped mid-frame → current frame completes normally; next frame no rden, RGB=0, syncs unchanged.
- BPP=8, q=16'hE01C → pixel 0 R=F,G=0,B=0; pixel 1 R=0,G=F,B=0.
- reset_n low mid-line, no clock edge → outputs at reset values immediately; after release, counting restarts at (0,0).
